multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 49 ++++
 rtl/multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath/memory.
// The controller attaches through the master modport and the datapath side
// through the slave modport. Signal names keep the original port names.
//   instr_i               : instruction register contents
//   br_less_i, br_equal_i : branch comparator results
//   mem_ready_i           : memory completes the current request
//   mem_req_o, mem_wren_o, adr_sel_o : memory request, store, address source
//   ir_wren_o, pc_wren_o, pc_sel_o   : IR load, PC load, PC source
//   br_un_o, opa_sel_o, opb_sel_o, alu_op_o : comparator/ALU controls
//   rd_wren_o, wb_sel_o   : register write-back
//   insn_vld_o, illegal_o, err_o     : retire, illegal, memory-timeout pulses
//   state_o               : current controller state (debug)
`timescale 1ns/1ps
interface multicycle_ctrl_if;
  logic [31:0] instr_i;
  logic        br_less_i;
  logic        br_equal_i;
  logic        mem_ready_i;
  logic        mem_req_o;
  logic        mem_wren_o;
  logic        adr_sel_o;
  logic        ir_wren_o;
  logic        pc_wren_o;
  logic        pc_sel_o;
  logic        br_un_o;
  logic        opa_sel_o;
  logic        opb_sel_o;
  logic [3:0]  alu_op_o;
  logic        rd_wren_o;
  logic [1:0]  wb_sel_o;
  logic        insn_vld_o;
  logic        illegal_o;
  logic        err_o;
  logic [2:0]  state_o;

  modport master (
    input  instr_i, br_less_i, br_equal_i, mem_ready_i,
    output mem_req_o, mem_wren_o, adr_sel_o, ir_wren_o, pc_wren_o, pc_sel_o,
           br_un_o, opa_sel_o, opb_sel_o, alu_op_o, rd_wren_o, wb_sel_o,
           insn_vld_o, illegal_o, err_o, state_o
  );

  modport slave (
    output instr_i, br_less_i, br_equal_i, mem_ready_i,
    input  mem_req_o, mem_wren_o, adr_sel_o, ir_wren_o, pc_wren_o, pc_sel_o,
           br_un_o, opa_sel_o, opb_sel_o, alu_op_o, rd_wren_o, wb_sel_o,
           insn_vld_o, illegal_o, err_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : multicycle_ctrl_if.master, all control/status signals
// Optional feature: define MEM_TIMEOUT_EN to abandon memory requests that
// stall for 15 consecutive cycles (err_o pulse, return to FETCH). Without it
// memory is waited on indefinitely and err_o is held at 0.
`timescale 1ns/1ps
module multicycle_ctrl (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_e;

  typedef enum logic [4:0] {
    OPC_R     = 5'b01100,
    OPC_I     = 5'b00100,
    OPC_LOAD  = 5'b00000,
    OPC_STORE = 5'b01000,
    OPC_BR    = 5'b11000,
    OPC_LUI   = 5'b01101,
    OPC_AUIPC = 5'b00101,
    OPC_JAL   = 5'b11011,
    OPC_JALR  = 5'b11001
  } opc_e;

  state_e     state_q;
  state_e     state_next;
  logic [4:0] opc;
  logic [2:0] funct3;
  logic       bit30;
  logic       is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic       opc_legal;
  logic       exec_illegal;
  logic       br_taken;
  alu_e       alu_op;
  logic       opa_sel;
  logic       opb_sel;
  logic       br_un;
  logic       timeout;
  logic       unused_instr_bits;

  assign opc    = bus.instr_i[6:2];
  assign funct3 = bus.instr_i[14:12];
  assign bit30  = bus.instr_i[30];
  assign unused_instr_bits = ^{bus.instr_i[31], bus.instr_i[29:15],
                               bus.instr_i[11:7], bus.instr_i[1:0]};

  always_comb begin
    is_r      = (opc == OPC_R);
    is_i      = (opc == OPC_I);
    is_ld     = (opc == OPC_LOAD);
    is_st     = (opc == OPC_STORE);
    is_br     = (opc == OPC_BR);
    is_lui    = (opc == OPC_LUI);
    is_auipc  = (opc == OPC_AUIPC);
    is_jal    = (opc == OPC_JAL);
    is_jalr   = (opc == OPC_JALR);
    opc_legal = is_r | is_i | is_ld | is_st | is_br | is_lui | is_auipc | is_jal | is_jalr;
  end

  // R and I-ALU use all eight funct3 codes; only branches have holes.
  assign exec_illegal = is_br && (funct3 == 3'b010 || funct3 == 3'b011);

  always_comb begin
    case (funct3)
      3'b000:  br_taken = bus.br_equal_i;
      3'b001:  br_taken = ~bus.br_equal_i;
      3'b100:  br_taken = bus.br_less_i;
      3'b101:  br_taken = ~bus.br_less_i;
      3'b110:  br_taken = bus.br_less_i;
      3'b111:  br_taken = ~bus.br_less_i;
      default: br_taken = 1'b0;
    endcase
  end

  // ALU/operand controls depend only on the instruction, so they hold
  // steady from EXEC through MEM/WB while instr_i is stable.
  always_comb begin
    alu_op  = ALU_ADD;
    opa_sel = 1'b0;
    opb_sel = 1'b0;
    br_un   = 1'b0;
    if (is_r || is_i) begin
      opb_sel = is_i;
      case (funct3)
        3'b000:  alu_op = (is_r && bit30) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = bit30 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (is_lui) begin
      alu_op  = ALU_PASSB;
      opb_sel = 1'b1;
    end else if (is_ld || is_st || is_jalr) begin
      opb_sel = 1'b1;
    end else if (is_auipc || is_jal || is_br) begin
      opa_sel = 1'b1;
      opb_sel = 1'b1;
      br_un   = is_br && (funct3[2:1] == 2'b11);
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [3:0] to_cnt;

  // Counts consecutive stalled cycles; only non-zero while parked in
  // FETCH or MEM because any state change clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i || timeout || state_next != state_q) begin
      to_cnt <= '0;
    end else if ((state_q == FETCH || state_q == MEM) && !bus.mem_ready_i) begin
      to_cnt <= to_cnt + 4'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout = (to_cnt == 4'hF);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      FETCH:  if (!timeout && bus.mem_ready_i) state_next = DECODE;
      DECODE: state_next = opc_legal ? EXEC : FETCH;
      EXEC: begin
        if (is_br)              state_next = FETCH;
        else if (is_ld || is_st) state_next = MEM;
        else                     state_next = WB;
      end
      MEM: begin
        if (timeout)                  state_next = FETCH;
        else if (bus.mem_ready_i)     state_next = is_ld ? WB : FETCH;
      end
      WB:      state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Everything is forced low while rst_i is high, independent of state.
  // A timeout abandons the request: the stalled cycle drops mem_req_o.
  always_comb begin
    bus.mem_req_o  = 1'b0;
    bus.mem_wren_o = 1'b0;
    bus.adr_sel_o  = 1'b0;
    bus.ir_wren_o  = 1'b0;
    bus.pc_wren_o  = 1'b0;
    bus.pc_sel_o   = 1'b0;
    bus.br_un_o    = 1'b0;
    bus.opa_sel_o  = 1'b0;
    bus.opb_sel_o  = 1'b0;
    bus.alu_op_o   = '0;
    bus.rd_wren_o  = 1'b0;
    bus.wb_sel_o   = '0;
    bus.insn_vld_o = 1'b0;
    bus.illegal_o  = 1'b0;
    bus.err_o      = 1'b0;
    bus.state_o    = '0;
    if (!rst_i) begin
      bus.state_o = state_q;
      if ((state_q inside {EXEC, MEM, WB}) && !exec_illegal) begin
        bus.alu_op_o  = alu_op;
        bus.opa_sel_o = opa_sel;
        bus.opb_sel_o = opb_sel;
        bus.br_un_o   = br_un;
      end
      case (state_q)
        FETCH: begin
          if (timeout) begin
            bus.err_o = 1'b1;
          end else begin
            bus.mem_req_o = 1'b1;
            bus.ir_wren_o = bus.mem_ready_i;
          end
        end
        DECODE: begin
          if (!opc_legal) begin
            bus.illegal_o = 1'b1;
            bus.pc_wren_o = 1'b1;
          end
        end
        EXEC: begin
          if (exec_illegal) begin
            bus.illegal_o = 1'b1;
            bus.pc_wren_o = 1'b1;
          end else if (is_br) begin
            bus.pc_wren_o  = 1'b1;
            bus.pc_sel_o   = br_taken;
            bus.insn_vld_o = 1'b1;
          end
        end
        MEM: begin
          if (timeout) begin
            bus.err_o = 1'b1;
          end else begin
            bus.mem_req_o  = 1'b1;
            bus.adr_sel_o  = 1'b1;
            bus.mem_wren_o = is_st;
            if (bus.mem_ready_i && is_st) begin
              bus.pc_wren_o  = 1'b1;
              bus.insn_vld_o = 1'b1;
            end
          end
        end
        WB: begin
          bus.rd_wren_o  = 1'b1;
          bus.pc_wren_o  = 1'b1;
          bus.wb_sel_o   = (is_jal || is_jalr) ? 2'd2 : (is_ld ? 2'd1 : 2'd0);
          bus.pc_sel_o   = is_jal || is_jalr;
          bus.insn_vld_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A transaction-level model expands
// each instruction (kind, wait counts) into the expected per-cycle outputs.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR, K_ILL} kind_e;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_wren, adr_sel, ir_wren, pc_wren, pc_sel, br_un, opa, opb;
    logic [3:0] alu;
    logic       rd_wren;
    logic [1:0] wb_sel;
    logic       insn_vld, illegal, err;
  } outs_t;

  typedef struct {
    logic        rdy;
    logic [31:0] ins;
    logic        less;
    logic        eq;
    outs_t       exp;
  } vec_t;

  localparam logic [4:0] OPC [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                     5'b01101, 5'b00101, 5'b11011, 5'b11001};
  // ALU code per funct3 for register/immediate arithmetic (ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND);
  // bit 30 selects the +1 variant (SUB, SRA).
  localparam logic [3:0] F3_OP [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  logic clk = 1'b0;
  logic rst;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  vec_t trace[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic cycle(input logic r, input logic rdy, input logic [31:0] ins,
                       input logic less, input logic eq, output outs_t obs);
    @(negedge clk);
    rst             = r;
    bus.mem_ready_i = rdy;
    bus.instr_i     = ins;
    bus.br_less_i   = less;
    bus.br_equal_i  = eq;
    #1;
    obs = {bus.state_o, bus.mem_req_o, bus.mem_wren_o, bus.adr_sel_o, bus.ir_wren_o,
           bus.pc_wren_o, bus.pc_sel_o, bus.br_un_o, bus.opa_sel_o, bus.opb_sel_o,
           bus.alu_op_o, bus.rd_wren_o, bus.wb_sel_o, bus.insn_vld_o, bus.illegal_o,
           bus.err_o};
    @(posedge clk);
  endtask

  task automatic push(input logic rdy, input logic [31:0] ins, input logic less,
                      input logic eq, input outs_t e);
    vec_t v;
    v.rdy = rdy; v.ins = ins; v.less = less; v.eq = eq; v.exp = e;
    trace.push_back(v);
  endtask

  function automatic logic [31:0] make_insn(input kind_e k);
    logic [31:0] ins;
    logic [4:0]  opc;
    logic [2:0]  f3;
    ins = $urandom;
    if (k == K_ILL) begin
      do opc = 5'($urandom_range(0, 31));
      while (opc inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                         5'b01101, 5'b00101, 5'b11011, 5'b11001});
    end else begin
      opc = OPC[int'(k)];
    end
    ins[6:0] = {opc, 2'b11};
    f3 = ins[14:12];
    if (k == K_BR && f3[2:1] == 2'b01 && $urandom_range(0, 3) != 0) f3[2] = 1'b1;
    ins[14:12] = f3;
    if ((k == K_R || k == K_I) && f3 != 3'd0 && f3 != 3'd5) ins[30] = 1'b0;
    return ins;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction starting in FETCH.
  task automatic model_insn(input kind_e k, input logic [31:0] ins, input logic less,
                            input logic eq, input int unsigned wf, input int unsigned wm);
    outs_t o;
    outs_t ctl;
    logic [2:0] f3;
    logic       b30;
    f3  = ins[14:12];
    b30 = ins[30];
    ctl = '0;
    case (k)
      K_R, K_I: begin
        ctl.alu = F3_OP[f3];
        if (b30 && (f3 == 3'd5 || (k == K_R && f3 == 3'd0))) ctl.alu = ctl.alu + 4'd1;
        ctl.opb = (k == K_I);
      end
      K_LD, K_ST, K_JALR: ctl.opb = 1'b1;
      K_LUI: begin ctl.alu = 4'b1010; ctl.opb = 1'b1; end
      K_AUIPC, K_JAL: begin ctl.opa = 1'b1; ctl.opb = 1'b1; end
      K_BR: begin ctl.opa = 1'b1; ctl.opb = 1'b1; ctl.br_un = (f3 == 3'd6 || f3 == 3'd7); end
      default: ;
    endcase
    for (int unsigned i = 0; i < wf; i++) begin
      o = '0;
      if (TIMEOUT_EN && (i % 16) == 15) o.err = 1'b1;
      else o.mem_req = 1'b1;
      push(1'b0, $urandom, less, eq, o);
    end
    o = '0; o.mem_req = 1'b1; o.ir_wren = 1'b1;
    push(1'b1, $urandom, less, eq, o);
    o = '0; o.st = 3'd1;
    if (k == K_ILL) begin
      o.illegal = 1'b1; o.pc_wren = 1'b1;
      push(1'($urandom_range(0, 1)), ins, less, eq, o);
      return;
    end
    push(1'($urandom_range(0, 1)), ins, less, eq, o);
    o = ctl; o.st = 3'd2;
    if (k == K_BR) begin
      if (f3 == 3'd2 || f3 == 3'd3) begin
        o = '0; o.st = 3'd2; o.illegal = 1'b1; o.pc_wren = 1'b1;
      end else begin
        o.pc_wren = 1'b1; o.insn_vld = 1'b1;
        o.pc_sel = (f3[2] ? less : eq) ^ f3[0];
      end
      push(1'($urandom_range(0, 1)), ins, less, eq, o);
      return;
    end
    push(1'($urandom_range(0, 1)), ins, less, eq, o);
    if (k == K_LD || k == K_ST) begin
      o = ctl; o.st = 3'd3; o.mem_req = 1'b1; o.adr_sel = 1'b1; o.mem_wren = (k == K_ST);
      for (int unsigned i = 0; i < wm; i++) push(1'b0, ins, less, eq, o);
      if (k == K_ST) begin o.pc_wren = 1'b1; o.insn_vld = 1'b1; end
      push(1'b1, ins, less, eq, o);
      if (k == K_ST) return;
    end
    o = ctl; o.st = 3'd4; o.rd_wren = 1'b1; o.pc_wren = 1'b1; o.insn_vld = 1'b1;
    o.wb_sel = (k == K_JAL || k == K_JALR) ? 2'd2 : ((k == K_LD) ? 2'd1 : 2'd0);
    o.pc_sel = (k == K_JAL || k == K_JALR);
    push(1'($urandom_range(0, 1)), ins, less, eq, o);
  endtask

  task automatic test_reset();
    outs_t obs;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b1, obs);
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, outs_t'('0));
      end
    end
    trace.delete();
    model_insn(K_R, make_insn(K_R), 1'b0, 1'b0, 2, 0);
    foreach (trace[i]) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL reset_exit[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_add();
    outs_t obs;
    trace.delete();
    model_insn(K_R, 32'h002081B3, 1'b0, 1'b0, 0, 0);
    foreach (trace[i]) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL add[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_bne();
    outs_t obs;
    trace.delete();
    model_insn(K_BR, 32'h00209463, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    foreach (trace[i]) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL bne[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_lw_wait();
    outs_t obs;
    trace.delete();
    model_insn(K_LD, 32'h0000A183, 1'b0, 1'b0, 0, 3);
    foreach (trace[i]) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL lw_wait[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_illegal();
    outs_t obs;
    trace.delete();
    model_insn(K_ILL, 32'h0000007F, 1'b0, 1'b0, 0, 0);
    model_insn(K_BR, 32'h0020A063, 1'b1, 1'b1, 1, 0);
    foreach (trace[i]) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_reset_in_mem();
    outs_t obs;
    trace.delete();
    model_insn(K_ST, 32'h0030A023, 1'b0, 1'b0, 0, 5);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL sw_pre_reset[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
    cycle(1'b1, 1'b1, 32'h0030A023, 1'b0, 1'b0, obs);
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL sw_reset_cycle: got %h expected %h", obs, outs_t'('0));
    end
    trace.delete();
    model_insn(K_I, make_insn(K_I), 1'b0, 1'b0, 1, 0);
    foreach (trace[i]) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL sw_post_reset[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_timeout();
    outs_t obs;
    trace.delete();
    model_insn(K_I, make_insn(K_I), 1'b0, 1'b0, 20, 0);
    foreach (trace[i]) begin
      cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
      vectors++;
      if (obs !== trace[i].exp) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_random();
    outs_t obs;
    logic [31:0] vals [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int n = 0; n < 60; n++) begin
      kind_e       k;
      logic [31:0] ins, a, b;
      logic        less, eq;
      k   = kind_e'($urandom_range(0, 9));
      ins = make_insn(k);
      a   = vals[$urandom_range(0, 3)];
      b   = vals[$urandom_range(0, 3)];
      eq  = (a == b);
      less = (ins[14:13] == 2'b11) ? (a < b) : ($signed(a) < $signed(b));
      trace.delete();
      model_insn(k, ins, less, eq, $urandom_range(0, 3), $urandom_range(0, 3));
      foreach (trace[i]) begin
        cycle(1'b0, trace[i].rdy, trace[i].ins, trace[i].less, trace[i].eq, obs);
        vectors++;
        if (obs !== trace[i].exp) begin
          miscompares++;
          $display("FAIL random[%0d.%0d] ins=%h: got %h expected %h", n, i, ins, obs, trace[i].exp);
        end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.mem_ready_i = 1'b0;
    bus.instr_i     = '0;
    bus.br_less_i   = 1'b0;
    bus.br_equal_i  = 1'b0;
    test_reset();
    test_add();
    test_bne();
    test_lw_wait();
    test_illegal();
    test_reset_in_mem();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
